// File: rtl/matmul_accel_slave_pkg.sv
// Shared definitions for the matrix-multiply accelerator slave.
// Register map regions, control/status bits and FSM states.
package matmul_accel_slave_pkg;

  localparam logic [1:0] RGN_REG = 2'd0;
  localparam logic [1:0] RGN_A   = 2'd1;
  localparam logic [1:0] RGN_B   = 2'd2;
  localparam logic [1:0] RGN_C   = 2'd3;

  localparam logic [5:0] OFS_CTRL   = 6'd0;
  localparam logic [5:0] OFS_STATUS = 6'd1;
  localparam logic [5:0] OFS_CYCLES = 6'd2;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  localparam int MAX_ELEMS = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_STORE
  } state_t;

endpackage

// File: rtl/matmul_accel_slave_if.sv
// Native PicoRV32-style memory bus between interconnect and accelerator.
// Master drives request fields, slave returns ready pulse and read data.
interface matmul_accel_slave_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/matmul_accel_slave_mac_unit.sv
// Registered signed multiply-accumulate, one product per enabled cycle.
// Clear has priority over enable; sum wraps at the accumulator width.
module matmul_mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [ACC_WIDTH-1:0]  o_acc
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    r_acc;

  assign w_prod = i_a * i_b;
  assign o_acc  = r_acc;

  // accumulate sign-extended product, clear on request
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_acc <= '0;
    else if (i_en)
      r_acc <= r_acc + ACC_WIDTH'(w_prod);
  end

endmodule

// File: rtl/matmul_accel_slave.sv
// Memory-mapped C = A*B accelerator with one sequential MAC engine.
// Bus decode, A/B/C buffers and the sequencing FSM live here.
module matmul_accel_slave
  import matmul_accel_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int P          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  matmul_accel_slave_if.slave  bus,
  output logic                 busy,
  output logic                 irq_done
);

  localparam logic [5:0] LM = 6'(M - 1);
  localparam logic [5:0] LN = 6'(N - 1);
  localparam logic [5:0] LP = 6'(P - 1);

  logic                  r_ready;
  logic [31:0]           r_rdata;
  state_t                r_state;
  logic [5:0]            r_i;
  logic [5:0]            r_j;
  logic [5:0]            r_k;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_irq;
  logic [31:0]           r_cnt;
  logic [31:0]           r_cycles;
  logic [DATA_WIDTH-1:0] r_a [MAX_ELEMS];
  logic [DATA_WIDTH-1:0] r_b [MAX_ELEMS];
  logic [ACC_WIDTH-1:0]  r_c [MAX_ELEMS];

  logic [1:0]            w_rgn;
  logic [5:0]            w_idx;
  logic                  w_wr;
  logic                  w_ctrl_wr;
  logic                  w_start;
  logic                  w_clr_done;
  logic                  w_a_ok;
  logic                  w_b_ok;
  logic                  w_c_ok;
  logic [5:0]            w_a_idx;
  logic [5:0]            w_b_idx;
  logic [5:0]            w_c_idx;
  logic [31:0]           w_rd;
  logic [ACC_WIDTH-1:0]  w_acc;
  logic                  w_unused_bits;

  assign w_rgn = bus.mem_addr[9:8];
  assign w_idx = bus.mem_addr[7:2];

  // a write lands at the end of the ready cycle, while valid is still held
  assign w_wr       = r_ready & bus.mem_valid & bus.mem_wstrb[0];
  assign w_ctrl_wr  = w_wr & (w_rgn == RGN_REG) & (w_idx == OFS_CTRL);
  assign w_start    = w_ctrl_wr & bus.mem_wdata[CTRL_START]
                    & (r_state == S_IDLE);
  assign w_clr_done = w_ctrl_wr & bus.mem_wdata[CTRL_CLR];

  assign w_a_ok = {1'b0, w_idx} < 7'(M * N);
  assign w_b_ok = {1'b0, w_idx} < 7'(N * P);
  assign w_c_ok = {1'b0, w_idx} < 7'(M * P);

  assign w_a_idx = r_i * 6'(N) + r_k;
  assign w_b_idx = r_k * 6'(P) + r_j;
  assign w_c_idx = r_i * 6'(P) + r_j;

  assign w_unused_bits = ^{bus.mem_addr[31:10], bus.mem_addr[1:0],
                           bus.mem_wdata[31:DATA_WIDTH],
                           bus.mem_wstrb[3:1]};

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign busy          = r_busy;
  assign irq_done      = r_irq;

  matmul_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start | (r_state == S_STORE)),
    .i_en  (r_state == S_MAC),
    .i_a   (r_a[w_a_idx]),
    .i_b   (r_b[w_b_idx]),
    .o_acc (w_acc)
  );

  // read mux, sign-extending buffer elements to the bus width
  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      (w_rgn == RGN_REG): begin
        if (w_idx == OFS_STATUS) begin
          w_rd[STAT_BUSY] = r_busy;
          w_rd[STAT_DONE] = r_done;
        end else if (w_idx == OFS_CYCLES) begin
          w_rd = r_cycles;
        end
      end
      (w_rgn == RGN_A):
        if (w_a_ok) w_rd = 32'($signed(r_a[w_idx]));
      (w_rgn == RGN_B):
        if (w_b_ok) w_rd = 32'($signed(r_b[w_idx]));
      (w_rgn == RGN_C):
        if (w_c_ok) w_rd = 32'($signed(r_c[w_idx]));
      default: w_rd = '0;
    endcase
  end

  // one-cycle ready pulse with data registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= bus.mem_valid & ~r_ready;
      r_rdata <= (bus.mem_valid & ~r_ready) ? w_rd : '0;
    end
  end

  // operand buffers take bus writes only when idle; C is filled by the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < MAX_ELEMS; e++) begin
        r_a[e] <= '0;
        r_b[e] <= '0;
        r_c[e] <= '0;
      end
    end else begin
      if (w_wr && !r_busy && (w_rgn == RGN_A) && w_a_ok)
        r_a[w_idx] <= bus.mem_wdata[DATA_WIDTH-1:0];
      if (w_wr && !r_busy && (w_rgn == RGN_B) && w_b_ok)
        r_b[w_idx] <= bus.mem_wdata[DATA_WIDTH-1:0];
      if (r_state == S_STORE)
        r_c[w_c_idx] <= w_acc;
    end
  end

  // sequencer: N MAC cycles then one STORE per output element
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
      r_cnt    <= '0;
      r_cycles <= '0;
    end else begin
      r_irq <= 1'b0;
      if (w_clr_done)
        r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_cnt <= r_cnt + 32'd1;
          if (r_k == LN)
            r_state <= S_STORE;
          else
            r_k <= r_k + 6'd1;
        end
        S_STORE: begin
          r_cnt <= r_cnt + 32'd1;
          r_k   <= '0;
          if (r_i == LM && r_j == LP) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_irq    <= 1'b1;
            r_cycles <= r_cnt + 32'd1;
          end else begin
            r_state <= S_MAC;
            if (r_j == LP) begin
              r_j <= '0;
              r_i <= r_i + 6'd1;
            end else begin
              r_j <= r_j + 6'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_accel_slave.sv
// Scoreboard bench for matmul_accel_slave: driver queues expected reads,
// a negedge monitor pops and compares on every mem_ready pulse.
module tb_matmul_accel_slave;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] CTRL   = BASE + 32'h000;
  localparam logic [31:0] STATUS = BASE + 32'h004;
  localparam logic [31:0] CYCLES = BASE + 32'h008;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic irq_done;

  matmul_accel_slave_if bus ();

  matmul_accel_slave dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .irq_done (irq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_vec  = 0;
  int n_err  = 0;
  int n_irq  = 0;
  int n_busy = 0;
  int ta [4][4];
  int tbm[4][4];
  int tc [4][4];

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] a_addr(int i, int k);
    return BASE + 32'h100 + 32'(4 * (i * 4 + k));
  endfunction

  function automatic logic [31:0] b_addr(int k, int j);
    return BASE + 32'h200 + 32'(4 * (k * 4 + j));
  endfunction

  function automatic logic [31:0] c_addr(int i, int j);
    return BASE + 32'h300 + 32'(4 * (i * 4 + j));
  endfunction

  // monitor: irq/busy tallies and scoreboard pop on each ready pulse
  always @(negedge clk) begin : mon
    exp_t e;
    if (irq_done) n_irq++;
    if (busy) n_busy++;
    if (bus.mem_ready) begin
      if (q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        if (e.chk) check(e.name, bus.mem_rdata, e.exp);
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit c,
                      input logic [31:0] e, input string nm);
    exp_t t;
    int lat;
    t.chk = c;
    t.exp = e;
    t.name = nm;
    q.push_back(t);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.mem_ready && lat < 8);
    check({nm, "_lat"}, 32'(lat), 32'd1);
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string nm);
    xfer(a, 32'h0, 4'h0, 1'b1, e, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(a, d, 4'hF, 1'b0, 32'h0, "wr");
  endtask

  task automatic load_ab();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        wr(a_addr(i, k), 32'(ta[i][k]));
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        wr(b_addr(k, j), 32'(tbm[k][j]));
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (busy && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 1000) check("busy_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_c(input string nm);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        rd(c_addr(i, j), 32'(tc[i][j]), nm);
  endtask

  task automatic fill_ident();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ta[i][j]  = (i == j) ? 1 : 0;
        tbm[i][j] = i * 4 + j;
        tc[i][j]  = i * 4 + j;
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    int i0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, bus.mem_ready}, 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    rd(STATUS, 32'h0, "rst_status");
    rd(CYCLES, 32'h0, "rst_cycles");
    rd(a_addr(0, 0), 32'h0, "rst_a00");
    rd(b_addr(3, 3), 32'h0, "rst_b33");
    rd(c_addr(0, 0), 32'h0, "rst_c00");

    // identity times ramp
    fill_ident();
    load_ab();
    b0 = n_busy;
    wr(CTRL, 32'h1);
    wait_idle();
    check("t1_busy_cycles", 32'(n_busy - b0), 32'd80);
    check_c("t1_c");
    rd(CYCLES, 32'd80, "t1_cycles");
    rd(STATUS, 32'h2, "t1_status");

    // constant matrices, irq pulse, CLEAR_DONE
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ta[i][j] = 2;
        tbm[i][j] = 3;
        tc[i][j] = 24;
      end
    load_ab();
    i0 = n_irq;
    wr(CTRL, 32'h1);
    wait_idle();
    check("t2_irq_count", 32'(n_irq - i0), 32'd1);
    check_c("t2_c");
    rd(STATUS, 32'h2, "t2_status_done");
    wr(CTRL, 32'h2);
    rd(STATUS, 32'h0, "t2_status_clr");

    // extreme signed values
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ta[i][j] = -128;
        tbm[i][j] = -128;
        tc[i][j] = 65536;
      end
    load_ab();
    rd(a_addr(2, 1), 32'hFFFF_FF80, "t3_a_sext");
    wr(CTRL, 32'h1);
    wait_idle();
    check_c("t3_c");
    for (int k = 0; k < 4; k++) begin
      wr(a_addr(0, k), 32'd127);
      wr(b_addr(k, 0), 32'hFFFF_FFFF);
    end
    rd(b_addr(1, 0), 32'hFFFF_FFFF, "t3_b_sext");
    wr(CTRL, 32'h1);
    wait_idle();
    rd(c_addr(0, 0), 32'hFFFF_FE04, "t3_c00");
    rd(c_addr(0, 1), 32'hFFFF_0200, "t3_c01");
    rd(c_addr(1, 0), 32'h0000_0200, "t3_c10");
    rd(c_addr(1, 1), 32'h0001_0000, "t3_c11");

    // writes and START during a run are dropped
    fill_ident();
    load_ab();
    b0 = n_busy;
    i0 = n_irq;
    wr(CTRL, 32'h1);
    wr(a_addr(0, 0), 32'd5);
    wr(CTRL, 32'h1);
    wait_idle();
    check("t4_busy_cycles", 32'(n_busy - b0), 32'd80);
    check("t4_irq_count", 32'(n_irq - i0), 32'd1);
    rd(a_addr(0, 0), 32'd1, "t4_a00");
    check_c("t4_c");

    // unmapped offsets and back-to-back valid
    rd(BASE + 32'h00C, 32'h0, "t5_0x00c");
    rd(BASE + 32'h3FC, 32'h0, "t5_0x3fc");
    for (int p = 0; p < 3; p++) begin
      exp_t t;
      t.chk = 1'b1;
      t.exp = 32'h0;
      t.name = "t5_b2b_data";
      q.push_back(t);
    end
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h00C;
    bus.mem_wstrb = 4'h0;
    for (int p = 0; p < 6; p++) begin
      @(posedge clk);
      #1;
      check("t5_b2b_ready", {31'b0, bus.mem_ready},
            (p % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.mem_valid = 1'b0;
    @(posedge clk);
    #1;

    // reset in the middle of a run
    i0 = n_irq;
    wr(CTRL, 32'h1);
    repeat (28) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_busy", {31'b0, busy}, 32'd0);
    rd(STATUS, 32'h0, "t6_status");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        tc[i][j] = 0;
    check_c("t6_c_zero");
    rd(a_addr(1, 1), 32'h0, "t6_a11");
    check("t6_no_irq", 32'(n_irq - i0), 32'd0);
    fill_ident();
    load_ab();
    wr(CTRL, 32'h1);
    wait_idle();
    check_c("t6_c_rerun");
    rd(CYCLES, 32'd80, "t6_cycles");

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
